// File: rtl/secuenciador_corrimiento.sv
// -----------------------------------------------------------------------------
// secuenciador_corrimiento
//
// Sequencing stage for an external N-bit combinational shift unit that moves
// data by one bit per application. An operand, an operation code and a step
// count are captured on `start`. The working register then feeds the unit's F
// input once per clock, and the unit's S output is written back, until the
// requested number of steps has run. This turns the 1-bit-per-step unit into
// multi-bit shifts and rotates.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   start      in   request; sampled only while idle
//   dato_in    in   [N]   operand, captured with start
//   op         in   [3]   shift-unit operation code, captured with start
//   cant       in   [CW]  number of unit applications, captured with start
//   F_u        out  [N]   to shift unit F (the working register)
//   H_u        out  [3]   to shift unit H (000 = transfer while not shifting)
//   S_u        in   [N]   from shift unit S (combinational from F_u/H_u)
//   resultado  out  [N]   final word; valid with fin, held until next completion
//   ocupado    out  high while an operation is in progress (SHIFT and DONE)
//   fin        out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module secuenciador_corrimiento #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  dato_in,
  input  logic [2:0]    op,
  input  logic [CW-1:0] cant,
  output logic [N-1:0]  F_u,
  output logic [2:0]    H_u,
  input  logic [N-1:0]  S_u,
  output logic [N-1:0]  resultado,
  output logic          ocupado,
  output logic          fin
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  reg_q;        // working word, feeds the unit
  logic [2:0]    op_q;         // captured operation code
  logic [CW-1:0] cnt_q;        // remaining unit applications
  logic [N-1:0]  resultado_q;  // final word

  logic          last_step;    // this SHIFT edge performs the final application

  assign last_step = (cnt_q <= CW'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of inferred
  // latches when a branch does not assign state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (cant == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ocupado = 1'b0;
    fin     = 1'b0;
    H_u     = 3'b000;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        ocupado = 1'b1;
        H_u     = op_q;
      end
      DONE: begin
        ocupado = 1'b1;
        fin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign F_u       = reg_q;
  assign resultado = resultado_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  //
  // resultado_q is loaded on the edge that enters DONE, so the final word is
  // already visible while fin is high: from S_u on the last SHIFT edge, or
  // straight from dato_in when a zero-step request goes IDLE -> DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q       <= '0;
      op_q        <= 3'b000;
      cnt_q       <= '0;
      resultado_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            reg_q <= dato_in;
            op_q  <= op;
            cnt_q <= cant;
            if (cant == '0) begin
              resultado_q <= dato_in;
            end
          end
        end
        SHIFT: begin
          reg_q <= S_u;
          cnt_q <= cnt_q - CW'(1);
          if (last_step) begin
            resultado_q <= S_u;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_corrimiento.sv
// -----------------------------------------------------------------------------
// Testbench for secuenciador_corrimiento (N=4, CW=3).
// The 1-bit shift unit is modelled here and wired between F_u/H_u and S_u.
// Each request pushes its expected final word and completion cycle to a
// scoreboard queue; the entry is popped and compared when fin appears.
// -----------------------------------------------------------------------------
module tb_secuenciador_corrimiento;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  dato_in;
  logic [2:0]    op;
  logic [CW-1:0] cant;
  logic [N-1:0]  F_u;
  logic [2:0]    H_u;
  logic [N-1:0]  S_u;
  logic [N-1:0]  resultado;
  logic          ocupado;
  logic          fin;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [N-1:0] res;
    int           due;
  } exp_t;

  exp_t sb[$];

  secuenciador_corrimiento #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dato_in   (dato_in),
    .op        (op),
    .cant      (cant),
    .F_u       (F_u),
    .H_u       (H_u),
    .S_u       (S_u),
    .resultado (resultado),
    .ocupado   (ocupado),
    .fin       (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One application of the shift unit.
  function automatic logic [N-1:0] unit_f(input logic [N-1:0] f, input logic [2:0] h);
    case (h)
      3'b001:  return {f[N-2:0], 1'b0};
      3'b010:  return {1'b0, f[N-1:1]};
      3'b011:  return '0;
      3'b101:  return {f[N-2:0], f[N-1]};
      3'b111:  return {f[0], f[N-1:1]};
      default: return f;
    endcase
  endfunction

  function automatic logic [N-1:0] ref_calc(input logic [N-1:0] d, input logic [2:0] o,
                                            input int c);
    logic [N-1:0] r;
    r = d;
    for (int i = 0; i < c; i++) r = unit_f(r, o);
    return r;
  endfunction

  always_comb S_u = unit_f(F_u, H_u);

  // fin must never be high on two consecutive cycles.
  logic fin_prev = 1'b0;
  always @(negedge clk) begin
    if (fin === 1'b1) begin
      total++;
      if (fin_prev === 1'b1) begin
        bad++;
        $display("FAIL fin_width: fin high two cycles in a row at cycle %0d", cyc);
      end
    end
    fin_prev = fin;
  end

  // Drive one request; it is sampled on the next rising edge.
  task automatic issue(input logic [N-1:0] d, input logic [2:0] o, input logic [CW-1:0] c,
                       input logic [N-1:0] exp_res);
    @(negedge clk);
    dato_in = d;
    op      = o;
    cant    = c;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{exp_res, cyc + int'(c)});
  endtask

  // Wait (bounded) for fin, pop the scoreboard and compare; then check hold.
  task automatic wait_fin(input string name);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fin !== 1'b1 && n < 40);
    total++;
    if (fin !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: fin not seen within %0d cycles", name, n);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_unexpected: fin with empty scoreboard at cycle %0d", name, cyc);
      return;
    end
    e = sb.pop_front();
    total++;
    if (resultado !== e.res) begin
      bad++;
      $display("FAIL %s_result: got %b expected %b", name, resultado, e.res);
    end
    if (cyc !== e.due) begin
      bad++;
      $display("FAIL %s_latency: fin at cycle %0d expected %0d", name, cyc, e.due);
    end
    @(negedge clk);
    total++;
    if (resultado !== e.res) begin
      bad++;
      $display("FAIL %s_hold: got %b expected %b", name, resultado, e.res);
    end
  endtask

  // Count fin pulses over a window; none are expected.
  task automatic expect_quiet(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (fin !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL %s_quiet: got %0d fin pulses expected 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    start   = 1'b0;
    dato_in = '0;
    op      = 3'b000;
    cant    = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (resultado !== 4'b0000 || fin !== 1'b0 || ocupado !== 1'b0 || H_u !== 3'b000) begin
      bad++;
      $display("FAIL reset_state: got res=%b fin=%b ocupado=%b H_u=%b expected 0000/0/0/000",
               resultado, fin, ocupado, H_u);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_shl();
    issue(4'b0011, 3'b001, 3'd2, 4'b1100);
    wait_fin("shl2");
    repeat (4) @(negedge clk);
    total++;
    if (resultado !== 4'b1100) begin
      bad++;
      $display("FAIL shl2_long_hold: got %b expected 1100", resultado);
    end
    issue(4'b1111, 3'b001, 3'd7, 4'b0000);
    wait_fin("shl7_overflow");
  endtask

  task automatic test_shr_ror();
    issue(4'b1000, 3'b010, 3'd3, 4'b0001);
    wait_fin("shr3_logical");
    issue(4'b0001, 3'b111, 3'd1, 4'b1000);
    wait_fin("ror1");
  endtask

  task automatic test_rol_wrap();
    issue(4'b1000, 3'b101, 3'd5, 4'b0001);
    wait_fin("rol5_wrap");
    issue(4'b1011, 3'b101, 3'd4, 4'b1011);
    wait_fin("rol4_identity");
  endtask

  task automatic test_edges();
    issue(4'b0110, 3'b001, 3'd0, 4'b0110);
    wait_fin("cant0");
    issue(4'b1111, 3'b011, 3'd1, 4'b0000);
    wait_fin("zero_op");
    issue(4'b1010, 3'b100, 3'd3, 4'b1010);
    wait_fin("transfer_op");
  endtask

  task automatic test_ignore_start();
    issue(4'b0001, 3'b001, 3'd3, 4'b1000);
    @(negedge clk);
    dato_in = 4'b1111;
    op      = 3'b111;
    cant    = 3'd2;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fin("ignore_start");
    expect_quiet("ignore_start", 10);
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_idle: ocupado=%b expected 0", ocupado);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    dato_in = 4'b0011;
    op      = 3'b001;
    cant    = 3'd1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back('{4'b0110, k + 1});
    sb.push_back('{4'b0110, k + 4});
    wait_fin("b2b_first");
    @(negedge clk);
    start = 1'b0;
    wait_fin("b2b_second");
    expect_quiet("b2b", 10);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    dato_in = 4'b1010;
    op      = 3'b101;
    cant    = 3'd6;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (resultado !== 4'b0000 || fin !== 1'b0 || ocupado !== 1'b0 ||
        H_u !== 3'b000 || F_u !== 4'b0000) begin
      bad++;
      $display("FAIL reset_abort: got res=%b fin=%b ocupado=%b H_u=%b F_u=%b expected all zero",
               resultado, fin, ocupado, H_u, F_u);
    end
    expect_quiet("reset_held", 2);
    rst_n = 1'b1;
    expect_quiet("after_abort", 10);
    issue(4'b0101, 3'b101, 3'd2, 4'b0101);
    wait_fin("after_reset_op");
  endtask

  task automatic test_random();
    logic [N-1:0]  d;
    logic [2:0]    o;
    logic [CW-1:0] c;
    for (int i = 0; i < 8; i++) begin
      d = N'($urandom_range(0, 15));
      o = 3'($urandom_range(0, 7));
      c = CW'($urandom_range(0, 7));
      issue(d, o, c, ref_calc(d, o, int'(c)));
      wait_fin("random");
    end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_shr_ror();
    test_rol_wrap();
    test_edges();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secuenciador_corrimiento.md
Name: secuenciador_corrimiento

Overview:
- Sequencing stage wrapped around the N-bit combinational shift unit.
- Latches an operand, an operation code and a step count on `start`.
- Drives the shift unit's `F`/`H` inputs and registers its `S` output back into a working register, once per clock, for the requested number of steps.
- Returns the final word with a one-cycle `fin` pulse; gives multi-bit shifts/rotates from a 1-bit-per-step unit.

Parameters:
- N, 4, data width; equals the shift unit's N.
- CW, 3, width of step-count input `cant`; max steps 2^CW-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  request; sampled only in IDLE.
- dato_in  input  N  operand, captured with start.
- op  input  3  operation code, captured with start.
- cant  input  CW  number of steps, captured with start.
- F_u  output  N  to shift unit F; equals working register.
- H_u  output  3  to shift unit H.
- S_u  input  N  from shift unit S (combinational result of F_u/H_u).
- resultado  output  N  final word; held until next completion.
- ocupado  output  1  high in SHIFT and DONE.
- fin  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release): state=IDLE; working reg, op_reg, cnt, resultado = 0; fin=0; ocupado=0; H_u=3'b000.
- Shift unit op codes, all at width N:
  - 001 = logical shl by 1.
  - 010 = logical shr by 1; sign bit NOT replicated.
  - 011 = all zeros.
  - 101 = rotate left by 1.
  - 111 = rotate right by 1.
  - Any other code = transfer (unchanged).
- IDLE:
  - ocupado=0. H_u=3'b000, so the unit transfers.
  - On start=1: reg<=dato_in, op_reg<=op, cnt<=cant.
  - If cant==0, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - H_u=op_reg. Each cycle: reg<=S_u, cnt<=cnt-1.
  - When cnt==1 on this edge, go to DONE.
  - Exactly `cant` unit applications occur.
- DONE (one cycle):
  - fin=1. resultado<=reg (registered on the edge leaving DONE, visible from the next cycle). Then go to IDLE.
  - Spec choice: resultado is updated on the DONE->IDLE edge; fin is asserted during DONE. The implementation must make resultado valid in the same cycle fin is high. To do so, load resultado on the edge entering DONE: on the last SHIFT edge load S_u; on the IDLE->DONE edge for cant==0 load dato_in.
- Latency: start sampled at edge k; fin high during cycle k+cant+1. For cant=0, fin is high in cycle k+1.
- start while ocupado=1 is ignored; no queuing.
- start held high continuously: a new operation begins in the first IDLE cycle after DONE.
- Op codes 011 and transfer still run `cant` steps; the results are idempotent.
- Rotations wrap. cant >= N is legal: rol by N returns the operand; shl by >= N yields 0.
- Async reset mid-operation aborts immediately:
  - All registers are cleared and resultado is forced to 0.
  - No fin pulse.
- fin is never high for more than one consecutive cycle.

Test Plan:
- Reset → resultado=0, fin=0, ocupado=0, H_u=000. Then start, dato_in=4'b0011, op=001, cant=2 → fin at cycle k+3, resultado=4'b1100; resultado holds afterwards.
- dato_in=4'b1000, op=010, cant=3 → resultado=4'b0001 (logical, no sign extension). With op=111, cant=1, dato_in=4'b0001 → 4'b1000.
- dato_in=4'b1000, op=101, cant=5 → resultado=4'b0001 (wrap). cant=4 with dato_in=4'b1011 → 4'b1011.
- cant=0, op=001, dato_in=4'b0110 → fin in cycle k+1, resultado=4'b0110. Also: op=011, cant=1 → resultado=4'b0000.
- Second start pulsed during SHIFT with different data → ignored; first result intact. start held high → back-to-back operations, exactly one fin pulse each.
- rst_n dropped during SHIFT (cant=6) → outputs zero within the same cycle, no fin. After release, a new op completes correctly.
